prog_sequencer: RTL

Run controller for the program counter. Accepts a request to run one of three stored programs, forces the PC to that program's base address, and releases the PC to free-run. It then watches for the decoded halt instruction or a cycle-budget timeout and closes the run with a 4-phase Req/Ack handshake. It sits between the testbench/top level and the PC, driving the PC's load and hold (Start) controls.

---
 rtl/prog_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/prog_sequencer.sv
// -----------------------------------------------------------------------------
// prog_sequencer
//
// Run controller for the program counter. A run request selects one of three
// stored programs; the sequencer forces the PC to that program's base address
// for one cycle, then lets the PC free-run until either the decoded halt
// instruction is seen or the RUN-cycle budget is exhausted. The run is closed
// with a 4-phase Req/Ack handshake.
//
// Ports:
//   Clk_i         clock, all state changes on posedge
//   Reset_i       asynchronous active-high reset
//   Req_i         run request (level, held until Ack seen)
//   ProgId_i      program index 0..2 (3 is rejected), sampled on accept
//   Halt_i        current instruction decodes as halt
//   ProgCtr_i     current PC value
//   PcLoad_o      PC loads PcLoadAddr_o on next edge
//   PcLoadAddr_o  load target address
//   PcHold_o      freeze PC
//   Busy_o        high in LOAD and RUN
//   Ack_o         run complete (high in DONE)
//   Timeout_o     last run ended by budget rather than Halt
//   CycleCount_o  RUN cycles of current/last run
//   HaltAddr_o    PC value at which the run ended
// -----------------------------------------------------------------------------
module prog_sequencer #(
  parameter int          L       = 10,
  parameter int          P0_BASE = 0,
  parameter int          P1_BASE = 256,
  parameter int          P2_BASE = 512,
  parameter logic [15:0] MAX_CYC = 16'hFFFF
) (
  input  logic         Clk_i,
  input  logic         Reset_i,
  input  logic         Req_i,
  input  logic [1:0]   ProgId_i,
  input  logic         Halt_i,
  input  logic [L-1:0] ProgCtr_i,
  output logic         PcLoad_o,
  output logic [L-1:0] PcLoadAddr_o,
  output logic         PcHold_o,
  output logic         Busy_o,
  output logic         Ack_o,
  output logic         Timeout_o,
  output logic [15:0]  CycleCount_o,
  output logic [L-1:0] HaltAddr_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [L-1:0] load_addr_q, load_addr_d;
  logic [15:0]  cyc_q, cyc_d;
  logic         timeout_q, timeout_d;
  logic [L-1:0] halt_addr_q, halt_addr_d;

  logic [L-1:0] base_sel;
  logic [16:0]  cyc_inc;

  // Base address of the requested program; index 3 never reaches LOAD.
  always_comb begin
    base_sel = L'(P0_BASE);
    case (ProgId_i)
      2'd1:    base_sel = L'(P1_BASE);
      2'd2:    base_sel = L'(P2_BASE);
      default: base_sel = L'(P0_BASE);
    endcase
  end

  // One bit wider than the counter so the budget compare cannot wrap.
  assign cyc_inc = {1'b0, cyc_q} + 17'd1;

  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    cyc_d       = cyc_q;
    timeout_d   = timeout_q;
    halt_addr_d = halt_addr_q;
    case (state_q)
      S_IDLE: begin
        if (Req_i && (ProgId_i != 2'd3)) begin
          load_addr_d = base_sel;
          cyc_d       = 16'd0;
          timeout_d   = 1'b0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        // Halt wins over the budget when both land on the same edge.
        if (Halt_i) begin
          halt_addr_d = ProgCtr_i;
          cyc_d       = cyc_inc[15:0];
          state_d     = S_DONE;
        end else if (cyc_inc == {1'b0, MAX_CYC}) begin
          halt_addr_d = ProgCtr_i;
          cyc_d       = MAX_CYC;
          timeout_d   = 1'b1;
          state_d     = S_DONE;
        end else begin
          cyc_d = cyc_inc[15:0];
        end
      end
      S_DONE: begin
        if (!Req_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q     <= S_IDLE;
      load_addr_q <= '0;
      cyc_q       <= 16'd0;
      timeout_q   <= 1'b0;
      halt_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      cyc_q       <= cyc_d;
      timeout_q   <= timeout_d;
      halt_addr_q <= halt_addr_d;
    end
  end

  // Handshake and PC controls are pure decodes of the state register.
  assign PcLoad_o     = (state_q == S_LOAD);
  assign PcHold_o     = (state_q != S_RUN);
  assign Busy_o       = (state_q == S_LOAD) || (state_q == S_RUN);
  assign Ack_o        = (state_q == S_DONE);
  assign PcLoadAddr_o = load_addr_q;
  assign Timeout_o    = timeout_q;
  assign CycleCount_o = cyc_q;
  assign HaltAddr_o   = halt_addr_q;

endmodule
